// File: rtl/imem_boot_ctrl.sv
// Instruction memory boot controller: loads a program word stream,
// then serves single-cycle core fetches from the loaded image.
module imem_boot_ctrl #(
  parameter int DEPTH = 20,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic          reload,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_rvalid,
  output logic [31:0]   fetch_rdata,
  output logic          fetch_err,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          core_stall,
  output logic          boot_done,
  output logic          load_err,
  output logic [AW:0]   prog_len
);

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    ERR
  } state_e;

  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

  state_e      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] prog_len_q, prog_len_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;

  logic [AW-1:0] f_idx;
  logic          f_bad;
  logic          unused_addr_hi;

  assign f_idx = fetch_addr[AW+1:2];
  assign f_bad = (fetch_addr[1:0] != 2'b00) ||
                 ({1'b0, f_idx} >= prog_len_q);
  assign unused_addr_hi = ^fetch_addr[31:AW+2];

  // State, pointers and the one-deep fetch response pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      prog_len_q <= prog_len_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
    end
  end

  // Next state plus memory strobes; requests are ignored while in reset.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    prog_len_d = prog_len_q;
    rvalid_d   = 1'b0;
    err_d      = 1'b0;
    ld_ready   = 1'b0;
    core_stall = 1'b1;
    fetch_gnt  = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = wr_ptr_q[AW-1:0];
    mem_wdata  = '0;
    unique case (state_q)
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid && rst_n) begin
          mem_we    = 1'b1;
          mem_wdata = ld_data;
          wr_ptr_d  = wr_ptr_q + 1'b1;
          if (ld_last) begin
            state_d    = RUN;
            prog_len_d = wr_ptr_q + 1'b1;
          end else if (wr_ptr_q == LAST_IDX) begin
            state_d = ERR;
          end
        end
      end
      RUN: begin
        core_stall = 1'b0;
        mem_addr   = f_idx;
        if (reload) begin
          state_d    = LOAD;
          wr_ptr_d   = '0;
          prog_len_d = '0;
        end else if (fetch_req && rst_n) begin
          fetch_gnt = 1'b1;
          rvalid_d  = 1'b1;
          err_d     = f_bad;
          mem_re    = !f_bad;
        end
      end
      ERR: begin
        if (reload) begin
          state_d    = LOAD;
          wr_ptr_d   = '0;
          prog_len_d = '0;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  assign fetch_rvalid = rvalid_q;
  assign fetch_err    = rvalid_q & err_q;
  assign fetch_rdata  = (rvalid_q && !err_q) ? mem_rdata : '0;
  assign boot_done    = (state_q == RUN);
  assign load_err     = (state_q == ERR);
  assign prog_len     = prog_len_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl with a behavioural
// synchronous-read instruction memory.
module tb_imem_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        reload;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_gnt;
  logic        fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        fetch_err;
  logic        mem_we;
  logic        mem_re;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        core_stall;
  logic        boot_done;
  logic        load_err;
  logic [5:0]  prog_len;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [0:31];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  imem_boot_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .ld_ready     (ld_ready),
    .reload       (reload),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .fetch_rvalid (fetch_rvalid),
    .fetch_rdata  (fetch_rdata),
    .fetch_err    (fetch_err),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .core_stall   (core_stall),
    .boot_done    (boot_done),
    .load_err     (load_err),
    .prog_len     (prog_len)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_ld_ready"}, 32'(ld_ready), 32'd1);
    chk({p, "_stall"}, 32'(core_stall), 32'd1);
    chk({p, "_boot_done"}, 32'(boot_done), 32'd0);
    chk({p, "_load_err"}, 32'(load_err), 32'd0);
    chk({p, "_prog_len"}, 32'(prog_len), 32'd0);
    chk({p, "_rvalid"}, 32'(fetch_rvalid), 32'd0);
    chk({p, "_ferr"}, 32'(fetch_err), 32'd0);
    chk({p, "_rdata"}, fetch_rdata, 32'd0);
    chk({p, "_gnt"}, 32'(fetch_gnt), 32'd0);
    chk({p, "_we"}, 32'(mem_we), 32'd0);
    chk({p, "_re"}, 32'(mem_re), 32'd0);
    chk({p, "_maddr"}, 32'(mem_addr), 32'd0);
    chk({p, "_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    reload = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
    tick();
    tick();
    mid();
    chk_reset("rst");

    // load three words, last on the third
    tick(); rst_n = 1'b1;
    ld_valid = 1'b1; ld_data = 32'h00000013; ld_last = 1'b0;
    mid();
    chk("ld0_we", 32'(mem_we), 32'd1);
    chk("ld0_addr", 32'(mem_addr), 32'd0);
    chk("ld0_wdata", mem_wdata, 32'h00000013);
    tick(); ld_data = 32'h00100093;
    mid();
    chk("ld1_addr", 32'(mem_addr), 32'd1);
    chk("ld1_wdata", mem_wdata, 32'h00100093);
    tick(); ld_data = 32'h00200113; ld_last = 1'b1;
    mid();
    chk("ld2_addr", 32'(mem_addr), 32'd2);
    chk("ld2_we", 32'(mem_we), 32'd1);
    chk("ld2_boot_early", 32'(boot_done), 32'd0);
    tick(); ld_valid = 1'b0; ld_last = 1'b0;
    mid();
    chk("run_boot_done", 32'(boot_done), 32'd1);
    chk("run_prog_len", 32'(prog_len), 32'd3);
    chk("run_stall", 32'(core_stall), 32'd0);
    chk("run_ld_ready", 32'(ld_ready), 32'd0);
    chk("run_we_idle", 32'(mem_we), 32'd0);

    // back-to-back fetches 0x0, 0x4, 0x8
    tick(); fetch_req = 1'b1; fetch_addr = 32'h0;
    mid();
    chk("f0_gnt", 32'(fetch_gnt), 32'd1);
    chk("f0_re", 32'(mem_re), 32'd1);
    chk("f0_maddr", 32'(mem_addr), 32'd0);
    chk("f0_rvalid_early", 32'(fetch_rvalid), 32'd0);
    tick(); fetch_addr = 32'h4;
    mid();
    chk("f0_rvalid", 32'(fetch_rvalid), 32'd1);
    chk("f0_rdata", fetch_rdata, 32'h00000013);
    chk("f0_err", 32'(fetch_err), 32'd0);
    chk("f1_maddr", 32'(mem_addr), 32'd1);
    tick(); fetch_addr = 32'h8;
    mid();
    chk("f1_rvalid", 32'(fetch_rvalid), 32'd1);
    chk("f1_rdata", fetch_rdata, 32'h00100093);
    chk("f2_re", 32'(mem_re), 32'd1);
    tick(); fetch_req = 1'b0;
    mid();
    chk("f2_rvalid", 32'(fetch_rvalid), 32'd1);
    chk("f2_rdata", fetch_rdata, 32'h00200113);
    chk("f2_err", 32'(fetch_err), 32'd0);
    chk("f2_gnt_idle", 32'(fetch_gnt), 32'd0);
    tick();
    mid();
    chk("f_idle_rvalid", 32'(fetch_rvalid), 32'd0);
    chk("f_idle_rdata", fetch_rdata, 32'd0);

    // misaligned and out-of-program fetches
    tick(); fetch_req = 1'b1; fetch_addr = 32'h2;
    mid();
    chk("mis_gnt", 32'(fetch_gnt), 32'd1);
    chk("mis_re", 32'(mem_re), 32'd0);
    tick(); fetch_addr = 32'hC;
    mid();
    chk("oob_re", 32'(mem_re), 32'd0);
    chk("mis_rvalid", 32'(fetch_rvalid), 32'd1);
    chk("mis_err", 32'(fetch_err), 32'd1);
    chk("mis_rdata", fetch_rdata, 32'd0);
    tick(); fetch_req = 1'b0;
    mid();
    chk("oob_rvalid", 32'(fetch_rvalid), 32'd1);
    chk("oob_err", 32'(fetch_err), 32'd1);
    chk("oob_rdata", fetch_rdata, 32'd0);
    tick();
    mid();
    chk("err_pulse_end", 32'(fetch_err), 32'd0);

    // fetch then reload colliding with a new fetch
    tick(); fetch_req = 1'b1; fetch_addr = 32'h4;
    mid();
    chk("pre_rl_gnt", 32'(fetch_gnt), 32'd1);
    tick(); reload = 1'b1; fetch_addr = 32'h0;
    mid();
    chk("rl_gnt", 32'(fetch_gnt), 32'd0);
    chk("rl_re", 32'(mem_re), 32'd0);
    chk("rl_prev_rvalid", 32'(fetch_rvalid), 32'd1);
    chk("rl_prev_rdata", fetch_rdata, 32'h00100093);
    tick(); reload = 1'b0; fetch_req = 1'b0;
    mid();
    chk("rl_stall", 32'(core_stall), 32'd1);
    chk("rl_ld_ready", 32'(ld_ready), 32'd1);
    chk("rl_boot_done", 32'(boot_done), 32'd0);
    chk("rl_prog_len", 32'(prog_len), 32'd0);
    chk("rl_rvalid", 32'(fetch_rvalid), 32'd0);

    // 20 words with no last marker overflow into ERR
    for (int i = 0; i < 20; i++) begin
      tick(); ld_valid = 1'b1; ld_data = 32'(100 + i);
      mid();
      chk($sformatf("ovf_addr%0d", i), 32'(mem_addr), 32'(i));
      chk($sformatf("ovf_we%0d", i), 32'(mem_we), 32'd1);
    end
    tick();
    mid();
    chk("err_load_err", 32'(load_err), 32'd1);
    chk("err_ld_ready", 32'(ld_ready), 32'd0);
    chk("err_stall", 32'(core_stall), 32'd1);
    chk("err_we", 32'(mem_we), 32'd0);
    tick(); ld_valid = 1'b0; reload = 1'b1;
    mid();
    chk("err_hold", 32'(load_err), 32'd1);
    tick(); reload = 1'b0;
    mid();
    chk("err_rl_load_err", 32'(load_err), 32'd0);
    chk("err_rl_ld_ready", 32'(ld_ready), 32'd1);

    // reload ignored in LOAD; two words then reset
    tick(); reload = 1'b1; ld_valid = 1'b1; ld_data = 32'hAAAA0000;
    mid();
    chk("ld_rl_addr0", 32'(mem_addr), 32'd0);
    chk("ld_rl_we", 32'(mem_we), 32'd1);
    tick(); reload = 1'b0; ld_data = 32'hAAAA0001;
    mid();
    chk("ld_rl_addr1", 32'(mem_addr), 32'd1);
    tick(); rst_n = 1'b0; ld_valid = 1'b0;
    tick();
    mid();
    chk_reset("mid_rst");
    tick(); rst_n = 1'b1; ld_valid = 1'b1; ld_data = 32'hDEAD0001;
    ld_last = 1'b1;
    mid();
    chk("post_rst_addr", 32'(mem_addr), 32'd0);
    chk("post_rst_we", 32'(mem_we), 32'd1);
    tick(); ld_valid = 1'b0; ld_last = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h0; rst_n = 1'b0;
    mid();
    chk("rf_prog_len", 32'(prog_len), 32'd1);
    chk("rf_boot_done", 32'(boot_done), 32'd1);
    tick(); fetch_req = 1'b0;
    mid();
    chk("rf_rvalid", 32'(fetch_rvalid), 32'd0);
    chk("rf_boot_clr", 32'(boot_done), 32'd0);
    chk("rf_stall", 32'(core_stall), 32'd1);
    tick(); rst_n = 1'b1;
    mid();
    chk("rf_rvalid2", 32'(fetch_rvalid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_boot_ctrl.md
IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

Interface
REQ-001 Parameter DEPTH, default 20: number of 32-bit instruction words in the controlled instruction memory.
REQ-002 Parameter AW, default 5: word-index width; DEPTH SHALL be at most 2**AW.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 ld_valid  in  1  loader word valid; ld_data  in  32  loader word; ld_last  in  1  word is the final program word.
REQ-007 ld_ready  out  1  controller accepts the loader word this cycle.
REQ-008 reload  in  1  single-cycle request to re-enter program load.
REQ-009 fetch_req  in  1  core fetch request; fetch_addr  in  32  byte PC.
REQ-010 fetch_gnt  out  1  fetch accepted this cycle.
REQ-011 fetch_rvalid  out  1  fetch data valid; fetch_rdata  out  32  instruction; fetch_err  out  1  fetch rejected.
REQ-012 mem_we  out  1  write strobe; mem_re  out  1  read strobe; mem_addr  out  AW  word index; mem_wdata  out  32  write data; mem_rdata  in  32  read data, 1-cycle synchronous latency.
REQ-013 core_stall  out  1  core held; boot_done  out  1  program loaded; load_err  out  1  overflow flag; prog_len  out  AW+1  loaded word count.

Function
REQ-014 FSM states SHALL be LOAD, RUN and ERR; the reset state SHALL be LOAD.
REQ-015 In LOAD: ld_ready=1, core_stall=1, fetch_gnt=0.
REQ-016 In LOAD, when ld_valid&ld_ready: mem_we=1, mem_addr=wr_ptr, mem_wdata=ld_data, same cycle; wr_ptr SHALL increment by 1.
REQ-017 If the accepted word has ld_last=1, the next state SHALL be RUN, prog_len SHALL become wr_ptr+1, and boot_done SHALL be 1 from the next cycle.
REQ-018 If the word is accepted at wr_ptr==DEPTH-1 with ld_last=0, the next state SHALL be ERR.
REQ-019 In ERR: load_err=1, core_stall=1, ld_ready=0, no memory access; exit only via reload (to LOAD) or reset.
REQ-020 In RUN: core_stall=0, ld_ready=0, and fetch_gnt SHALL equal fetch_req & ~reload.
REQ-021 Granted fetch, cycle N: mem_re=1, mem_addr=fetch_addr[AW+1:2]; cycle N+1: fetch_rvalid=1, fetch_rdata=mem_rdata.
REQ-022 A granted fetch with fetch_addr[1:0]!=0, or index>=prog_len, SHALL drive mem_re=0 and produce fetch_rvalid=1, fetch_err=1, fetch_rdata=0 at N+1.
REQ-023 Back-to-back grants SHALL sustain one fetch per cycle.
REQ-024 reload in RUN or ERR SHALL move to LOAD next cycle, clear wr_ptr, boot_done, load_err and prog_len; reload in LOAD SHALL be ignored.
REQ-025 reload and fetch_req in the same RUN cycle: reload wins, no grant; a fetch granted the cycle before SHALL still complete its response.
REQ-026 mem_we and mem_re SHALL never be asserted in the same cycle.
REQ-027 fetch_rvalid, fetch_err and mem_we SHALL be single-cycle pulses, 0 when idle.

Reset
REQ-028 On rst_n=0 at a rising edge: state=LOAD, wr_ptr=0, prog_len=0, boot_done=0, load_err=0, fetch_rvalid=0, fetch_err=0, fetch_rdata=0, fetch_gnt=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, ld_ready=1, core_stall=1.
REQ-029 Reset SHALL override any in-flight load or fetch; no response pulse SHALL appear after reset for a request issued before it.

Verification
REQ-030 Load 3 words (0x00000013, 0x00100093, 0x00200113, last on third) -> mem_we at indices 0,1,2; prog_len=3; boot_done=1; core_stall=0 next cycle.
REQ-031 After load, fetch 0x0,0x4,0x8 on consecutive cycles -> fetch_rvalid on 3 consecutive cycles, data in order, fetch_err=0.
REQ-032 Fetch 0x2 and 0xC with prog_len=3 -> fetch_err=1, fetch_rdata=0, mem_re=0 for both.
REQ-033 Stream 20 words without ld_last -> ERR, load_err=1, ld_ready=0; reload -> LOAD, load_err=0.
REQ-034 reload and fetch_req in the same RUN cycle -> fetch_gnt=0, LOAD next cycle, core_stall=1.
REQ-035 rst_n=0 mid-load after 2 words -> all REQ-028 values next cycle; the reload starts at index 0.
